m_divide_8x4: RTL
=================

// Module: m_divide_8x4
// PURPOSE
//   Sequential unsigned divider: DIVIDEND_WIDTH-bit dividend / DIVISOR_WIDTH-bit divisor -> quotient + remainder.
//   Restoring algorithm, one quotient bit per clock. Inverse operation of the 4x4 unsigned multiplier.
//   Used by correlation/post-processing logic for amplitude normalisation, where a multi-cycle latency is acceptable.
// PARAMETERS
//   DIVIDEND_WIDTH  8  dividend and quotient width (bits)
//   DIVISOR_WIDTH   4  divisor and remainder width (bits); must be <= DIVIDEND_WIDTH
// PORTS
//   clk          in   1               system clock, rising edge
//   rst          in   1               asynchronous reset, active high
//   start_i      in   1               request; accepted only when ready_o=1
//   dividend_i   in   DIVIDEND_WIDTH  unsigned dividend, sampled with an accepted start_i
//   divisor_i    in   DIVISOR_WIDTH   unsigned divisor, sampled with an accepted start_i
//   ready_o      out  1               1 = IDLE, can accept start_i
//   valid_o      out  1               one-cycle pulse: quotient_o/remainder_o/div_zero_o are valid
//   quotient_o   out  DIVIDEND_WIDTH  quotient; held until the next accepted start
//   remainder_o  out  DIVISOR_WIDTH   remainder; held until the next accepted start
//   div_zero_o   out  1               divisor was zero; qualified by valid_o, held like quotient_o
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, ready_o=1, valid_o=0; quotient_o, remainder_o, div_zero_o, internal regs = 0.
//   Reset mid-operation aborts the operation. No valid_o is produced for the aborted request.
//   FSM: IDLE -> BUSY when start_i=1 and divisor_i!=0. IDLE -> DONE when start_i=1 and divisor_i==0.
//     BUSY -> DONE after DIVIDEND_WIDTH iterations. DONE -> IDLE unconditionally after 1 cycle.
//   ready_o=1 only in IDLE. start_i in BUSY/DONE is ignored, not queued. Operands are latched on accept.
//   Iteration k (k=0..DIVIDEND_WIDTH-1), MSB first:
//     partial = {rem, dividend[MSB-k]}  (width DIVISOR_WIDTH+1)
//     if partial >= divisor: rem = partial - divisor, qbit = 1
//     else:                  rem = partial[DIVISOR_WIDTH-1:0], qbit = 0
//   Iteration counter: $clog2(DIVIDEND_WIDTH+1) bits, cleared on accept.
//   Latency: start accepted at edge T -> valid_o high during the cycle following edge T+DIVIDEND_WIDTH (8 for defaults).
//     quotient_o/remainder_o update at that same edge.
//   Divide by zero: valid_o high during the cycle after edge T. quotient_o = all ones, remainder_o = 0, div_zero_o = 1.
//   div_zero_o = 0 for every non-zero divisor result.
//   Back-to-back: next start_i can be accepted in the cycle after valid_o, i.e. throughput 1 per DIVIDEND_WIDTH+2 cycles.
//   All outputs are registered. No combinational path from inputs to outputs except none (ready_o comes from state).
// CONFIGURATION
//   DIVIDE_ROUND_EN defined: quotient_o = floor + 1 when 2*remainder >= divisor (round half up).
//     The increment is applied at the final iteration edge, so latency is unchanged.
//     It cannot overflow: a quotient of all ones implies divisor = 1 and remainder = 0.
//     remainder_o still reports the true (unrounded) remainder. Divide-by-zero result is unchanged.
//   DIVIDE_ROUND_EN undefined: truncating quotient (floor). No rounding logic is generated.
// TESTING
//   200/7 -> valid_o 8 cycles after accept, q=28, r=4, div_zero_o=0; with DIVIDE_ROUND_EN q=29.
//   255/1 -> q=255, r=0; 5/15 -> q=0, r=5; 255/15 -> q=17, r=0 (also with round).
//   x/0 (dividend 0x5A) -> valid_o 1 cycle after accept, q=0xFF, r=0, div_zero_o=1; next op 9/3 -> q=3, div_zero_o=0.
//   start_i held high for 20 cycles with 100/9 -> exactly 2 results (q=11, r=1), ready_o low between them.
//   start_i pulsed during BUSY with other operands -> ignored; first result unaffected.
//   rst asserted 3 cycles into BUSY -> immediately ready_o=1, valid_o=0, outputs 0; no valid_o later; next 17/4 -> q=4, r=1.
//   Random sweep of all 256x16 operand pairs vs reference model in both configurations.

Source files
------------

// File: rtl/m_divide_8x4_if.sv
// Handshake and operand/result bundle for the m_divide_8x4 sequential divider.
// master drives requests and observes results; slave is the divider.
interface m_divide_8x4_if #(
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVISOR_WIDTH  = 4
);
  logic                      start_i;
  logic [DIVIDEND_WIDTH-1:0] dividend_i;
  logic [DIVISOR_WIDTH-1:0]  divisor_i;
  logic                      ready_o;
  logic                      valid_o;
  logic [DIVIDEND_WIDTH-1:0] quotient_o;
  logic [DIVISOR_WIDTH-1:0]  remainder_o;
  logic                      div_zero_o;

  modport master (
    output start_i, dividend_i, divisor_i,
    input  ready_o, valid_o, quotient_o, remainder_o, div_zero_o
  );

  modport slave (
    input  start_i, dividend_i, divisor_i,
    output ready_o, valid_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/m_divide_8x4.sv
// Sequential restoring unsigned divider, one quotient bit per clock, MSB first.
// Define DIVIDE_ROUND_EN to round the quotient half up instead of truncating.
module m_divide_8x4 #(
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVISOR_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  m_divide_8x4_if.slave        div_if
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [DIVIDEND_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIVISOR_WIDTH-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DIVIDEND_WIDTH-1:0] quotient_q, quotient_d;
  logic [DIVISOR_WIDTH-1:0]  remainder_q, remainder_d;
  logic                      div_zero_q, div_zero_d;

  logic [DIVISOR_WIDTH:0]    partial;
  logic                      qbit;
  logic [DIVISOR_WIDTH-1:0]  rem_n;
  logic [DIVIDEND_WIDTH-1:0] dvd_n;
  logic [DIVIDEND_WIDTH-1:0] quo_fin;

  // dvd_q shifts left each iteration; quotient bits enter at the LSB, so after
  // the last iteration it holds the full quotient.
  assign partial = {rem_q, dvd_q[DIVIDEND_WIDTH-1]};
  assign qbit    = (partial >= {1'b0, dsr_q});
  // The difference is always below the divisor, so the low bits are exact.
  assign rem_n   = qbit ? (partial[DIVISOR_WIDTH-1:0] - dsr_q) : partial[DIVISOR_WIDTH-1:0];
  assign dvd_n   = {dvd_q[DIVIDEND_WIDTH-2:0], qbit};

`ifdef DIVIDE_ROUND_EN
  logic round_up;
  // An all-ones floor quotient implies divisor 1 and remainder 0, so no wrap.
  assign round_up = ({rem_n, 1'b0} >= {1'b0, dsr_q});
  assign quo_fin  = dvd_n + DIVIDEND_WIDTH'(round_up);
`else
  assign quo_fin  = dvd_n;
`endif

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      IDLE: begin
        if (div_if.start_i) begin
          dvd_d = div_if.dividend_i;
          dsr_d = div_if.divisor_i;
          rem_d = '0;
          cnt_d = '0;
          if (div_if.divisor_i == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = '0;
            div_zero_d  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        dvd_d = dvd_n;
        rem_d = rem_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = DONE;
          quotient_d  = quo_fin;
          remainder_d = rem_n;
          div_zero_d  = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign div_if.ready_o     = (state_q == IDLE);
  assign div_if.valid_o     = (state_q == DONE);
  assign div_if.quotient_o  = quotient_q;
  assign div_if.remainder_o = remainder_q;
  assign div_if.div_zero_o  = div_zero_q;

endmodule
